// File: rtl/signature_checker.sv
// Serial frame signature checker: hunts for the preamble, verifies each
// frame bit-by-bit against SIG, and counts matched frames and sync losses.
module signature_checker #(
   parameter logic [255:0] SIG   = "Luke Vassallo Tiny Tapeout 2023.",
   parameter int unsigned  PRE_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   input  logic       din_valid,
   input  logic       clear,
   output logic       locked,
   output logic       frame_ok,
   output logic       sync_err,
   output logic [7:0] frame_cnt,
   output logic [7:0] err_cnt
);

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned FILL_W = $clog2(PRE_W + 1);

   localparam logic [PRE_W-1:0] PREAMBLE  = SIG[255 -: PRE_W];
   localparam logic [IDX_W-1:0] IDX_START = IDX_W'(255 - PRE_W);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(255);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PRE_W);
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PRE_W - 1);

   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] VERIFY = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   logic [1:0]        state, state_nx;
   logic [PRE_W-1:0]  shreg, shreg_nx, shifted;
   logic [FILL_W-1:0] fill, fill_nx;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic              frame_ok_c, sync_err_c;

   // fill counts fresh bits since the last resync so a cleared register
   // can never complete a preamble with fewer than PRE_W new bits
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      fill_nx    = fill;
      idx_nx     = idx;
      frame_ok_c = 1'b0;
      sync_err_c = 1'b0;
      shifted    = PRE_W'({shreg, din});
      if (din_valid) begin
         case (state)
            HUNT: begin
               shreg_nx = shifted;
               if (fill != FILL_MAX) fill_nx = fill + FILL_W'(1);
               if ((fill >= FILL_ARM) && (shifted == PREAMBLE)) begin
                  state_nx = VERIFY;
                  idx_nx   = IDX_START;
               end
            end
            VERIFY, LOCKED: begin
               if (din == SIG[idx]) begin
                  if (idx == '0) begin
                     frame_ok_c = 1'b1;
                     state_nx   = LOCKED;
                     idx_nx     = IDX_LAST;
                  end else begin
                     idx_nx = idx - IDX_W'(1);
                  end
               end else begin
                  sync_err_c = 1'b1;
                  state_nx   = HUNT;
                  shreg_nx   = '0;
                  fill_nx    = '0;
                  idx_nx     = '0;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= HUNT;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg    <= '0;
         fill     <= '0;
         idx      <= '0;
         locked   <= 1'b0;
         frame_ok <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         shreg    <= shreg_nx;
         fill     <= fill_nx;
         idx      <= idx_nx;
         locked   <= (state_nx == LOCKED);
         frame_ok <= frame_ok_c;
         sync_err <= sync_err_c;
      end
   end

   // clear wins over a same-cycle increment; counts stick at 255
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (clear)                               frame_cnt <= '0;
         else if (frame_ok_c && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
         if (clear)                               err_cnt <= '0;
         else if (sync_err_c && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
